// File: rtl/persistence_pair_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : persistence_pair_filter_if
// Description : Stream bundle for the persistence pair filter. Carries the
//               (birth, death) index pair input stream and the filtered
//               (birth_val, death_val, persistence) output stream.
//               master = upstream pair source and downstream consumer side,
//               slave  = filter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface persistence_pair_filter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    // Input pair stream
    logic                  pair_valid;
    logic                  pair_ready;
    logic [ADDR_WIDTH-1:0] pair_birth;
    logic [ADDR_WIDTH-1:0] pair_death;
    logic                  pair_last;

    // Output (surviving pair) stream
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_birth_val;
    logic [DATA_WIDTH-1:0] out_death_val;
    logic [DATA_WIDTH-1:0] out_persistence;

    modport master (
        output pair_valid, pair_birth, pair_death, pair_last, out_ready,
        input  pair_ready, out_valid, out_birth_val, out_death_val, out_persistence
    );

    modport slave (
        input  pair_valid, pair_birth, pair_death, pair_last, out_ready,
        output pair_ready, out_valid, out_birth_val, out_death_val, out_persistence
    );
endinterface
`default_nettype wire

// File: rtl/persistence_pair_filter.sv
`default_nettype none
// ============================================================================
// Module      : persistence_pair_filter
// Description : Maps (birth, death) simplex-index pairs to filtration values,
//               computes persistence, drops pairs below a session threshold
//               or with inverted values, and buffers survivors in a
//               first-word fall-through FIFO. Keeps per-session statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module persistence_pair_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic [DATA_WIDTH-1:0] threshold,
    input  wire logic                  fv_we,
    input  wire logic [ADDR_WIDTH-1:0] fv_addr,
    input  wire logic [DATA_WIDTH-1:0] fv_data,
    persistence_pair_filter_if.slave   bus,
    output logic      [ADDR_WIDTH:0]   kept_count,
    output logic      [ADDR_WIDTH:0]   dropped_count,
    output logic      [DATA_WIDTH-1:0] max_persistence,
    output logic                       busy,
    output logic                       done
);

    localparam int TABLE_DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int ENTRY_W     = 3 * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ESSENTIAL_IDX = '1;
    localparam logic [DATA_WIDTH-1:0] ALL_ONES      = '1;
    localparam logic [ADDR_WIDTH:0]   CNT_MAX       = '1;
    localparam logic [CNT_W:0]        OCC_LIMIT     = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_threshold;

    // Filtration table (not reset; frozen outside IDLE)
    logic [DATA_WIDTH-1:0] fv_table [TABLE_DEPTH];

    // S1: registered table read results
    logic                  r_s1_valid;
    logic                  r_s1_essential;
    logic [DATA_WIDTH-1:0] r_s1_birth_val;
    logic [DATA_WIDTH-1:0] r_s1_death_val;

    // S2: combinational decide stage operating on S1 registers
    logic                  w_s2_inverted;
    logic                  w_s2_keep;
    logic [DATA_WIDTH-1:0] w_s2_death_val;
    logic [DATA_WIDTH-1:0] w_s2_persistence;

    // Output FIFO
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_count;
    logic [ENTRY_W-1:0]    w_head;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [CNT_W:0]        w_occupancy;

    // Occupancy counts every pair already committed to reach the FIFO, so a
    // kept pair always finds space and the decide stage never has to stall.
    assign w_occupancy    = {1'b0, r_fifo_count} + {{CNT_W{1'b0}}, r_s1_valid};
    assign bus.pair_ready = (r_state == RUN) && (w_occupancy < OCC_LIMIT);
    assign w_accept       = bus.pair_valid && bus.pair_ready;

    // Table write port, honoured only while idle
    always_ff @(posedge clk) begin
        if (fv_we && (r_state == IDLE)) begin
            fv_table[fv_addr] <= fv_data;
        end
    end

    // S1 synchronous table lookups for the accepted pair
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_birth_val <= fv_table[bus.pair_birth];
            r_s1_death_val <= fv_table[bus.pair_death];
            r_s1_essential <= (bus.pair_death == ESSENTIAL_IDX);
        end
    end

    // S1 occupancy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    // S2 keep/drop decision; essential pairs bypass the threshold
    always_comb begin
        w_s2_death_val   = r_s1_death_val;
        w_s2_persistence = '0;
        w_s2_keep        = 1'b0;
        w_s2_inverted    = (r_s1_death_val < r_s1_birth_val);
        if (r_s1_essential) begin
            w_s2_death_val   = ALL_ONES;
            w_s2_persistence = ALL_ONES;
            w_s2_keep        = 1'b1;
        end else if (!w_s2_inverted) begin
            w_s2_persistence = r_s1_death_val - r_s1_birth_val;
            w_s2_keep        = (w_s2_persistence >= r_threshold);
        end
    end

    assign w_push = r_s1_valid && w_s2_keep;
    assign w_drop = r_s1_valid && !w_s2_keep;
    assign w_pop  = bus.out_valid && bus.out_ready;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[r_wr_ptr] <= {r_s1_birth_val, w_s2_death_val, w_s2_persistence};
        end
    end

    // FIFO pointers and fill count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Head of FIFO is presented directly; outputs read zero when empty
    assign w_head              = fifo_mem[r_rd_ptr];
    assign bus.out_valid       = (r_fifo_count != '0);
    assign bus.out_birth_val   = bus.out_valid ? w_head[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;
    assign bus.out_death_val   = bus.out_valid ? w_head[2*DATA_WIDTH-1:DATA_WIDTH]   : '0;
    assign bus.out_persistence = bus.out_valid ? w_head[DATA_WIDTH-1:0]              : '0;

    // Session FSM with registered busy/done and per-session statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_threshold     <= '0;
            kept_count      <= '0;
            dropped_count   <= '0;
            max_persistence <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;

            if (w_push) begin
                if (kept_count != CNT_MAX) begin
                    kept_count <= kept_count + 1'b1;
                end
                if (!r_s1_essential && (w_s2_persistence > max_persistence)) begin
                    max_persistence <= w_s2_persistence;
                end
            end
            if (w_drop && (dropped_count != CNT_MAX)) begin
                dropped_count <= dropped_count + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state         <= RUN;
                        r_threshold     <= threshold;
                        kept_count      <= '0;
                        dropped_count   <= '0;
                        max_persistence <= '0;
                        busy            <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept && bus.pair_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_s1_valid && (r_fifo_count == '0)) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_persistence_pair_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_persistence_pair_filter
// Description : Scoreboard bench for persistence_pair_filter. Expected pairs
//               are computed from a reference table model when a pair is
//               accepted and compared as the FIFO head is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_persistence_pair_filter;

    localparam int DW = 16;
    localparam int AW = 12;

    typedef struct {
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic [DW-1:0] p;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] threshold;
    logic          fv_we;
    logic [AW-1:0] fv_addr;
    logic [DW-1:0] fv_data;
    logic [AW:0]   kept_count;
    logic [AW:0]   dropped_count;
    logic [DW-1:0] max_persistence;
    logic          busy;
    logic          done;

    persistence_pair_filter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    persistence_pair_filter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .threshold       (threshold),
        .fv_we           (fv_we),
        .fv_addr         (fv_addr),
        .fv_data         (fv_data),
        .bus             (bus),
        .kept_count      (kept_count),
        .dropped_count   (dropped_count),
        .max_persistence (max_persistence),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            done_pulses = 0;
    int            accepted = 0;
    exp_t          sb[$];
    logic [DW-1:0] fv_m [0:(1<<AW)-1];
    logic [DW-1:0] m_thr;
    int            m_kept, m_dropped;
    logic [DW-1:0] m_max;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every FIFO handshake and checks
    // that a stalled head stays put.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_b, prev_d, prev_p;
    always @(negedge clk) begin
        if (done) done_pulses++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid) begin
                check("stall_hold", {bus.out_birth_val, bus.out_death_val, bus.out_persistence},
                      {prev_b, prev_d, prev_p});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_birth", bus.out_birth_val, e.b);
                    check("out_death", bus.out_death_val, e.d);
                    check("out_pers",  bus.out_persistence, e.p);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_b = bus.out_birth_val;
            prev_d = bus.out_death_val;
            prev_p = bus.out_persistence;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fv_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        fv_we = 1'b1; fv_addr = a; fv_data = d;
        step(1);
        fv_we = 1'b0;
        fv_m[a] = d;
    endtask

    task automatic start_session(input logic [DW-1:0] thr);
        start = 1'b1; threshold = thr;
        step(1);
        start = 1'b0;
        m_thr = thr; m_kept = 0; m_dropped = 0; m_max = '0;
    endtask

    // Reference decision for one accepted pair
    task automatic model_pair(input logic [AW-1:0] b, input logic [AW-1:0] d);
        exp_t e;
        e.b = fv_m[b];
        if (d == '1) begin
            e.d = '1; e.p = '1;
            sb.push_back(e); m_kept++;
        end else begin
            e.d = fv_m[d];
            if (e.d < e.b) begin
                m_dropped++;
            end else begin
                e.p = e.d - e.b;
                if (e.p >= m_thr) begin
                    sb.push_back(e); m_kept++;
                    if (e.p > m_max) m_max = e.p;
                end else begin
                    m_dropped++;
                end
            end
        end
    endtask

    task automatic send_pair(input logic [AW-1:0] b, input logic [AW-1:0] d, input logic last);
        int n = 0;
        logic ok = 1'b1;
        bus.pair_valid = 1'b1; bus.pair_birth = b; bus.pair_death = d; bus.pair_last = last;
        forever begin
            @(negedge clk);
            if (bus.pair_ready) break;
            n++;
            if (n >= 2000) begin
                check("pair_ready_timeout", 0, 1);
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.pair_valid = 1'b0; bus.pair_last = 1'b0;
        if (ok) begin
            accepted++;
            model_pair(b, d);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int p0 = done_pulses;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n >= 500) begin
                check({tag, "_done_timeout"}, 0, 1);
                break;
            end
        end
        check({tag, "_kept"},    kept_count, m_kept);
        check({tag, "_dropped"}, dropped_count, m_dropped);
        check({tag, "_max"},     max_persistence, m_max);
        check({tag, "_sb_empty"}, sb.size(), 0);
        step(3);
        check({tag, "_done_once"}, done_pulses - p0, 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; threshold = '0;
        fv_we = 1'b0; fv_addr = '0; fv_data = '0;
        bus.pair_valid = 1'b0; bus.pair_birth = '0; bus.pair_death = '0;
        bus.pair_last = 1'b0; bus.out_ready = 1'b1;
        m_thr = '0; m_kept = 0; m_dropped = 0; m_max = '0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid",  bus.out_valid, 0);
        check("rst_pair_ready", bus.pair_ready, 0);
        check("rst_busy",       busy, 0);
        check("rst_done",       done, 0);
        check("rst_kept",       kept_count, 0);
        check("rst_dropped",    dropped_count, 0);
        check("rst_max",        max_persistence, 0);
        step(1);

        for (int i = 0; i < 32; i++) fv_write(AW'(i), DW'(10 * i));

        // 1) threshold 0, two pairs
        start_session(16'd0);
        check("t1_busy", busy, 1);
        send_pair(12'd1, 12'd3, 1'b0);
        send_pair(12'd2, 12'd5, 1'b1);
        wait_done("t1");

        // 2) threshold 25 drops the shorter-lived pair
        start_session(16'd25);
        send_pair(12'd1, 12'd3, 1'b0);
        send_pair(12'd2, 12'd5, 1'b0);
        send_pair(12'd0, 12'd9, 1'b1);
        wait_done("t2");

        // 3) essential pair, excluded from max
        start_session(16'd0);
        send_pair(12'd4, 12'hFFF, 1'b1);
        wait_done("t3");

        // 5) backpressure: 20 pairs with downstream stalled
        bus.out_ready = 1'b0;
        start_session(16'd0);
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_pair(AW'(i), AW'(i + 2), i == 19);
            end
            begin
                step(40);
                check("t5_accepted_at_full", accepted, 16);
                check("t5_ready_low", bus.pair_ready, 0);
                check("t5_out_valid", bus.out_valid, 1);
                bus.out_ready = 1'b1;
            end
        join
        wait_done("t5");

        // 6) reset mid-session with 5 queued entries; table write in RUN ignored
        bus.out_ready = 1'b0;
        start_session(16'd0);
        for (int i = 0; i < 5; i++) send_pair(AW'(i), AW'(i + 1), 1'b0);
        step(3);
        fv_we = 1'b1; fv_addr = 12'd1; fv_data = 16'd999;
        step(1);
        fv_we = 1'b0;
        @(negedge clk);
        check("t6_pre_out_valid", bus.out_valid, 1);
        check("t6_pre_kept", kept_count, 5);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_kept", kept_count, 0);
        check("t6_dropped", dropped_count, 0);
        step(1);
        bus.out_ready = 1'b1;
        start_session(16'd0);
        send_pair(12'd1, 12'd3, 1'b1);
        wait_done("t6");

        // 4) inverted pair is dropped with no output
        fv_write(12'd7, 16'd50);
        fv_write(12'd8, 16'd20);
        start_session(16'd0);
        send_pair(12'd7, 12'd8, 1'b1);
        wait_done("t4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
